// File: rtl/stereo_pkg.sv
// Shared constants and state encoding for the stereo SAD front end
// (pixel packer and three-line buffer controller).
package stereo_pkg;

    localparam int unsigned PIX_W        = 8;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned PIX_PER_WORD = 4;

    localparam int unsigned DEF_WIDTH    = 740;
    localparam int unsigned DEF_HEIGHT   = 480;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_PAD  = 2'd2,
        ST_DROP = 2'd3
    } pack_state_t;

    // Keep lanes [0, keep) of the word, overwrite the rest with the pad pixel.
    function automatic logic [WORD_W-1:0] pad_word(
        input logic [WORD_W-1:0] word,
        input logic [2:0]        keep,
        input logic [PIX_W-1:0]  pad
    );
        logic [WORD_W-1:0] w_res;
        w_res = word;
        for (int unsigned i = 0; i < PIX_PER_WORD; i++) begin
            if (i >= 32'(keep)) w_res[i*PIX_W +: PIX_W] = pad;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/stereo_pixel_packer.sv
// Packs an 8-bit AXI4-Stream video feed into 32-bit words, forcing exactly
// WIDTH/4 words per line by padding short lines and truncating long ones.
module stereo_pixel_packer
    import stereo_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned LOG_WIDTH  = 10,
    parameter int unsigned HEIGHT     = DEF_HEIGHT,
    parameter int unsigned LOG_HEIGHT = 9,
    parameter logic [7:0]  PAD_VALUE  = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic [31:0] o_pixel_data,
    output logic        o_pixel_valid,
    output logic        o_line_err,
    output logic        o_frame_done
);

    localparam logic [LOG_WIDTH-1:0]  LAST_COL = LOG_WIDTH'(WIDTH - 1);
    localparam logic [LOG_WIDTH:0]    WIDTH_X  = (LOG_WIDTH+1)'(WIDTH);
    localparam logic [LOG_WIDTH:0]    THREE_X  = (LOG_WIDTH+1)'(PIX_PER_WORD - 1);
    localparam logic [LOG_WIDTH:0]    FOUR_X   = (LOG_WIDTH+1)'(PIX_PER_WORD);
    localparam logic [LOG_WIDTH:0]    ONE_X    = (LOG_WIDTH+1)'(1);
    localparam logic [LOG_HEIGHT-1:0] LAST_ROW = LOG_HEIGHT'(HEIGHT - 1);

    pack_state_t           r_state, w_state_next;
    logic [LOG_WIDTH-1:0]  r_col, w_col_next;
    logic [LOG_HEIGHT-1:0] r_row, w_row_next;
    logic                  r_restart, w_restart_next;
    logic [WORD_W-1:0]     r_word, w_word_next;
    logic [WORD_W-1:0]     r_data, w_data_next;
    logic                  r_valid, w_valid_next;
    logic                  r_err, w_err_next;
    logic                  r_done, w_done_next;

    logic                  w_tready, w_acc, w_pack_beat, w_line_end;
    logic [1:0]            w_lane;
    logic [WORD_W-1:0]     w_word_wr;
    logic [LOG_WIDTH:0]    w_bound, w_pad_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_restart <= 1'b0;
            r_word    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_col     <= w_col_next;
            r_row     <= w_row_next;
            r_restart <= w_restart_next;
            r_word    <= w_word_next;
            r_data    <= w_data_next;
            r_valid   <= w_valid_next;
            r_err     <= w_err_next;
            r_done    <= w_done_next;
        end
    end

    // Lane write of the current beat; w_bound is the next word boundary column.
    always_comb begin
        w_lane     = r_col[1:0];
        w_word_wr  = r_word;
        w_word_wr[w_lane*PIX_W +: PIX_W] = s_axis_tdata;
        w_bound    = ({1'b0, r_col} | THREE_X) + ONE_X;
        w_pad_next = {1'b0, r_col} + FOUR_X;
    end

    always_comb begin
        w_state_next   = r_state;
        w_col_next     = r_col;
        w_row_next     = r_row;
        w_restart_next = r_restart;
        w_word_next    = r_word;
        w_data_next    = r_data;
        w_valid_next   = 1'b0;
        w_err_next     = 1'b0;
        w_done_next    = 1'b0;
        w_pack_beat    = 1'b0;
        w_line_end     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_acc && s_axis_tuser) w_pack_beat = 1'b1;
            end
            ST_PACK: begin
                if (w_acc) begin
                    w_pack_beat = 1'b1;
                end else if (s_axis_tvalid && s_axis_tuser) begin
                    // SOF mid-line: close the line out, the held beat restarts the frame
                    w_err_next     = 1'b1;
                    w_restart_next = 1'b1;
                    w_state_next   = ST_PAD;
                    if (w_lane != 2'd0) begin
                        w_valid_next = 1'b1;
                        w_data_next  = pad_word(r_word, {1'b0, w_lane}, PAD_VALUE);
                        if (w_bound == WIDTH_X) w_line_end = 1'b1;
                        else                    w_col_next = w_bound[LOG_WIDTH-1:0];
                    end
                end
            end
            ST_PAD: begin
                w_valid_next = 1'b1;
                w_data_next  = {PIX_PER_WORD{PAD_VALUE}};
                if (w_pad_next == WIDTH_X) w_line_end = 1'b1;
                else                       w_col_next = w_pad_next[LOG_WIDTH-1:0];
            end
            ST_DROP: begin
                if (w_acc && s_axis_tlast) w_line_end = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_pack_beat) begin
            w_word_next  = w_word_wr;
            w_state_next = ST_PACK;
            w_col_next   = r_col + LOG_WIDTH'(1);
            if (s_axis_tuser) w_row_next = '0;
            if (r_col == LAST_COL) begin
                w_valid_next = 1'b1;
                w_data_next  = w_word_wr;
                if (s_axis_tlast) begin
                    w_line_end = 1'b1;
                end else begin
                    w_err_next   = 1'b1;
                    w_col_next   = '0;
                    w_state_next = ST_DROP;
                end
            end else if (s_axis_tlast) begin
                w_err_next   = 1'b1;
                w_valid_next = 1'b1;
                w_data_next  = pad_word(w_word_wr, {1'b0, w_lane} + 3'd1, PAD_VALUE);
                w_state_next = ST_PAD;
                if (w_bound == WIDTH_X) w_line_end = 1'b1;
                else                    w_col_next = w_bound[LOG_WIDTH-1:0];
            end else if (w_lane == 2'd3) begin
                w_valid_next = 1'b1;
                w_data_next  = w_word_wr;
            end
        end

        if (w_line_end) begin
            w_col_next = '0;
            if (w_restart_next) begin
                w_row_next     = '0;
                w_restart_next = 1'b0;
                w_state_next   = ST_PACK;
            end else if (w_row_next == LAST_ROW) begin
                w_row_next   = '0;
                w_done_next  = 1'b1;
                w_state_next = ST_IDLE;
            end else begin
                w_row_next   = w_row_next + LOG_HEIGHT'(1);
                w_state_next = ST_PACK;
            end
        end
    end

    always_comb begin
        w_tready = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE, ST_DROP: w_tready = 1'b1;
                ST_PACK:          w_tready = !(s_axis_tvalid && s_axis_tuser && (r_col != '0));
                default:          w_tready = 1'b0;
            endcase
        end
        w_acc = s_axis_tvalid && w_tready;
    end

    assign s_axis_tready = w_tready;
    assign o_pixel_data  = r_data;
    assign o_pixel_valid = r_valid;
    assign o_line_err    = r_err;
    assign o_frame_done  = r_done;

endmodule

// File: tb/tb_stereo_pixel_packer.sv
// Directed scoreboard bench for stereo_pixel_packer with an 8x2 frame.
module tb_stereo_pixel_packer;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] o_pixel_data;
    logic        o_pixel_valid;
    logic        o_line_err;
    logic        o_frame_done;

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        q[$];

    stereo_pixel_packer #(
        .WIDTH(8),
        .LOG_WIDTH(3),
        .HEIGHT(2),
        .LOG_HEIGHT(1),
        .PAD_VALUE(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast),
        .o_pixel_data(o_pixel_data),
        .o_pixel_valid(o_pixel_valid),
        .o_line_err(o_line_err),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] data, input logic err, input logic done);
        exp_t e;
        e.data = data;
        e.err  = err;
        e.done = done;
        q.push_back(e);
    endtask

    task automatic idle(input int unsigned n);
        s_axis_tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic beat(input logic [7:0] d, input logic user, input logic last);
        logic acc;
        acc = 1'b0;
        s_axis_tdata  = d;
        s_axis_tuser  = user;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            #1 acc = s_axis_tready;
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        if (!acc) chk("accept_timeout", {31'b0, acc}, 32'd1);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_line(input logic [7:0] base, input int unsigned n,
                             input logic user, input logic last, input logic gaps);
        for (int unsigned i = 0; i < n; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            beat(base + 8'(i), user && (i == 0), last && (i == n - 1));
        end
    endtask

    task automatic push_nominal();
        push(32'h03020100, 1'b0, 1'b0);
        push(32'h07060504, 1'b0, 1'b0);
        push(32'h0B0A0908, 1'b0, 1'b0);
        push(32'h0F0E0D0C, 1'b0, 1'b1);
    endtask

    // Scoreboard side: every word is matched against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_pixel_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_word", o_pixel_data, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("word_data", o_pixel_data, e.data);
                    chk("word_err", {31'b0, o_line_err}, {31'b0, e.err});
                    chk("word_done", {31'b0, o_frame_done}, {31'b0, e.done});
                end
            end else begin
                chk("stray_pulse", {30'b0, o_line_err, o_frame_done}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tready", {31'b0, s_axis_tready}, 32'd0);
        chk("rst_valid", {31'b0, o_pixel_valid}, 32'd0);
        chk("rst_data", o_pixel_data, 32'd0);
        chk("rst_pulses", {30'b0, o_line_err, o_frame_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal frame
        push_nominal();
        send_line(8'h00, 8, 1'b1, 1'b1, 1'b0);
        send_line(8'h08, 8, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Short first line, padded
        push(32'h00121110, 1'b1, 1'b0);
        push(32'h00000000, 1'b0, 1'b0);
        push(32'h33323130, 1'b0, 1'b0);
        push(32'h37363534, 1'b0, 1'b1);
        send_line(8'h10, 3, 1'b1, 1'b1, 1'b0);
        #1 chk("pad_tready", {31'b0, s_axis_tready}, 32'd0);
        send_line(8'h30, 8, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Long first line, truncated
        push(32'h23222120, 1'b0, 1'b0);
        push(32'h27262524, 1'b1, 1'b0);
        push(32'h43424140, 1'b0, 1'b0);
        push(32'h47464544, 1'b0, 1'b1);
        send_line(8'h20, 11, 1'b1, 1'b1, 1'b0);
        send_line(8'h40, 8, 1'b0, 1'b1, 1'b0);
        idle(3);

        // SOF arriving after 5 pixels of row 1
        push(32'h53525150, 1'b0, 1'b0);
        push(32'h57565554, 1'b0, 1'b0);
        push(32'h5B5A5958, 1'b0, 1'b0);
        push(32'h0000005C, 1'b1, 1'b0);
        push(32'h636261AA, 1'b0, 1'b0);
        push(32'h67666564, 1'b0, 1'b0);
        push(32'h6B6A6968, 1'b0, 1'b0);
        push(32'h6F6E6D6C, 1'b0, 1'b1);
        send_line(8'h50, 8, 1'b1, 1'b1, 1'b0);
        send_line(8'h58, 5, 1'b0, 1'b0, 1'b0);
        s_axis_tdata  = 8'hAA;
        s_axis_tuser  = 1'b1;
        s_axis_tvalid = 1'b1;
        #1 chk("sof_tready", {31'b0, s_axis_tready}, 32'd0);
        beat(8'hAA, 1'b1, 1'b0);
        for (int unsigned i = 1; i < 8; i++) beat(8'h60 + 8'(i), 1'b0, i == 7);
        send_line(8'h68, 8, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Garbage before SOF, then a gappy frame
        repeat (3) beat(8'hEE, 1'b0, 1'b0);
        push_nominal();
        send_line(8'h00, 8, 1'b1, 1'b1, 1'b1);
        send_line(8'h08, 8, 1'b0, 1'b1, 1'b1);
        idle(3);

        // Reset after 6 pixels
        push(32'h83828180, 1'b0, 1'b0);
        send_line(8'h80, 6, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", {31'b0, o_pixel_valid}, 32'd0);
        chk("midrst_data", o_pixel_data, 32'd0);
        chk("midrst_tready", {31'b0, s_axis_tready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        push_nominal();
        send_line(8'h00, 8, 1'b1, 1'b1, 1'b0);
        send_line(8'h08, 8, 1'b0, 1'b1, 1'b0);
        idle(5);

        chk("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
